// File: rtl/debug_reg_dumper.sv
// debug_reg_dumper: walks the register file's debug read port from register 0
// up to NUM_REGS-1, latches each word once and streams it to the debug UART TX
// as NB/NB_BYTE bytes, most significant byte first, over a valid/ready handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for i_start; o_busy low
// SET_ADDR | drive o_mips_register_number from the register counter
// LATCH    | capture debug-port data into the word buffer, clear byte counter
// SEND     | present bytes MSB first; advance on valid & ready
// NEXT     | step the register counter to the next register
// DONE     | one-cycle o_done pulse, then back to IDLE
module debug_reg_dumper #(
  parameter int NB       = 32,
  parameter int REGS     = 5,
  parameter int NUM_REGS = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [REGS-1:0]    o_mips_register_number,
  input  logic [NB-1:0]      i_mips_register_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NUM_BYTES = NB / NB_BYTE;
  localparam int BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NUM_BYTES - 1);
  localparam logic [REGS-1:0] LAST_REG  = REGS'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_ADDR,
    ST_LATCH,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [REGS-1:0] r_reg_cnt;
  logic [BCW-1:0]  r_byte_cnt;
  logic [NB-1:0]   r_word;
  logic [REGS-1:0] r_reg_num;

  logic                              w_xfer;
  logic                              w_last_byte;
  logic [BCW-1:0]                    w_byte_idx;
  logic [NUM_BYTES-1:0][NB_BYTE-1:0] w_bytes;

  // Byte 0 of the packed view is the least significant byte, so MSB-first
  // order reads the view from the top index down.
  assign w_bytes     = r_word;
  assign w_byte_idx  = LAST_BYTE - r_byte_cnt;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_xfer      = (r_state == ST_SEND) && i_tx_ready;

  assign o_mips_register_number = r_reg_num;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    w_next_state = r_state;
    o_tx_valid   = 1'b0;
    o_tx_data    = '0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next_state = ST_SET_ADDR;
        end
      end
      ST_SET_ADDR: begin
        w_next_state = ST_LATCH;
      end
      ST_LATCH: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = w_bytes[w_byte_idx];
        if (w_xfer && w_last_byte) begin
          w_next_state = (r_reg_cnt < LAST_REG) ? ST_NEXT : ST_DONE;
        end
      end
      ST_NEXT: begin
        w_next_state = ST_SET_ADDR;
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Register/byte counters, address register and word buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_reg_cnt  <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_reg_num  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_reg_cnt <= '0;
          end
        end
        ST_SET_ADDR: begin
          r_reg_num <= r_reg_cnt;
        end
        ST_LATCH: begin
          r_word     <= i_mips_register_data;
          r_byte_cnt <= '0;
        end
        ST_SEND: begin
          if (w_xfer && !w_last_byte) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          // Saturate so the counter can never run past the last register.
          if (r_reg_cnt != LAST_REG) begin
            r_reg_cnt <= r_reg_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
